// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg : shared constants and types for the LED pattern sequencer.
//   Default geometry (slots per period, slot-time width), FSM state codes,
//   the stop-command encoding and the parsed-command record.
// -----------------------------------------------------------------------------
package led_pkg;

   localparam int N_SLOTS_DEF = 8;
   localparam int TIME_W_DEF  = 32;

   // FSM state codes
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // A slot time of zero means "stop the sequencer"
   localparam int STOP_TIME = 0;

   // One parsed command as delivered by the UART parser
   typedef struct packed {
      logic [N_SLOTS_DEF-1:0] ctrl;
      logic [TIME_W_DEF-1:0]  slot_time;
   } led_cmd_t;

endpackage : led_pkg

// File: rtl/led_slot_timer.sv
// -----------------------------------------------------------------------------
// led_slot_timer : slot-length counter for the LED sequencer.
//   Counts 0 .. i_limit-1 while enabled and flags the last cycle of each slot
//   with o_tc. i_load restarts the count at zero. The counter never exceeds
//   i_limit-1, so i_limit = 2^TIME_W-1 runs without overflow.
// -----------------------------------------------------------------------------
module led_slot_timer #(
   parameter int TIME_W = 32
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              i_en,
   input  logic              i_load,
   input  logic [TIME_W-1:0] i_limit,
   output logic              o_tc
);

   logic [TIME_W-1:0] r_cnt;
   logic [TIME_W-1:0] w_last;

   assign w_last = i_limit - TIME_W'(1);
   assign o_tc   = i_en && (r_cnt == w_last);

   // Slot counter: restart on load or terminal count, else count while enabled
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt <= '0;
      end else if (i_load || o_tc) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + TIME_W'(1);
      end
   end

endmodule : led_slot_timer

// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl : plays an N_SLOTS-bit pattern on one LED, one bit per slot,
//   bit0 first, repeating. New commands are held until the period boundary so
//   a pattern is never torn; a command arriving on the boundary cycle itself
//   is applied at that edge. A slot time of zero stops after the current
//   period.
// Build option: LED_SEQ_STATUS_EN adds period_done, a one-cycle pulse after
//   every completed period (including the last one before a stop).
// -----------------------------------------------------------------------------
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEF,
   parameter int TIME_W  = TIME_W_DEF
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               cmd_valid,
   input  logic [N_SLOTS-1:0] cmd_ctrl,
   input  logic [TIME_W-1:0]  cmd_time,
   output logic               Led,
   output logic               busy,
   output logic               cmd_pending
`ifdef LED_SEQ_STATUS_EN
   ,output logic              period_done
`endif
);

   localparam int               SLOT_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

   logic [0:0]         r_state;
   logic [SLOT_W-1:0]  r_slot;
   logic [N_SLOTS-1:0] r_act_ctrl;
   logic [TIME_W-1:0]  r_act_time;
   logic [N_SLOTS-1:0] r_pend_ctrl;
   logic [TIME_W-1:0]  r_pend_time;
   logic               r_pending;

   logic               w_run;
   logic               w_tc;
   logic               w_boundary;
   logic               w_start;
   logic               w_nxt_avail;
   logic [N_SLOTS-1:0] w_nxt_ctrl;
   logic [TIME_W-1:0]  w_nxt_time;

   assign w_run      = (r_state == ST_RUN);
   assign w_boundary = w_run && w_tc && (r_slot == LAST_SLOT);
   assign w_start    = !w_run && cmd_valid && (cmd_time != TIME_W'(STOP_TIME));

   // Command seen at the boundary: a same-cycle command beats the buffered one
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_nxt_avail = r_pending;
      w_nxt_ctrl  = r_pend_ctrl;
      w_nxt_time  = r_pend_time;
      if (cmd_valid) begin
         w_nxt_avail = 1'b1;
         w_nxt_ctrl  = cmd_ctrl;
         w_nxt_time  = cmd_time;
      end
   end

   led_slot_timer #(
      .TIME_W (TIME_W)
   ) u_slot_timer (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .i_en    (w_run),
      .i_load  (w_start),
      .i_limit (r_act_time),
      .o_tc    (w_tc)
   );

   // FSM, slot index and active/pending command registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_act_ctrl  <= '0;
         r_act_time  <= '0;
         r_pend_ctrl <= '0;
         r_pend_time <= '0;
         r_pending   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state    <= ST_RUN;
                  r_act_ctrl <= cmd_ctrl;
                  r_act_time <= cmd_time;
                  r_slot     <= '0;
               end
            end
            ST_RUN: begin
               if (w_boundary) begin
                  r_slot    <= '0;
                  r_pending <= 1'b0;
                  if (w_nxt_avail) begin
                     if (w_nxt_time == TIME_W'(STOP_TIME)) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_act_ctrl <= w_nxt_ctrl;
                        r_act_time <= w_nxt_time;
                     end
                  end
               end else begin
                  if (w_tc) begin
                     r_slot <= r_slot + SLOT_W'(1);
                  end
                  if (cmd_valid) begin
                     r_pend_ctrl <= cmd_ctrl;
                     r_pend_time <= cmd_time;
                     r_pending   <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef LED_SEQ_STATUS_EN
   logic r_period_done;

   // One-cycle pulse after the edge that closes each period
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_period_done <= 1'b0;
      end else begin
         r_period_done <= w_boundary;
      end
   end

   assign period_done = r_period_done;
`endif

   assign Led         = w_run ? r_act_ctrl[r_slot] : 1'b0;
   assign busy        = w_run;
   assign cmd_pending = r_pending;

endmodule : led_seq_ctrl

// File: tb/tb_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_seq_ctrl : directed bench for led_seq_ctrl (8 slots, 32-bit time).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
//   period_done is checked only when LED_SEQ_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_led_seq_ctrl;
   import led_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        cmd_valid;
   logic [7:0]  cmd_ctrl;
   logic [31:0] cmd_time;
   logic        Led;
   logic        busy;
   logic        cmd_pending;
`ifdef LED_SEQ_STATUS_EN
   logic        period_done;
`endif

   int n_vec = 0;
   int n_err = 0;

   led_seq_ctrl dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ctrl    (cmd_ctrl),
      .cmd_time    (cmd_time),
      .Led         (Led),
      .busy        (busy),
      .cmd_pending (cmd_pending)
`ifdef LED_SEQ_STATUS_EN
      ,.period_done (period_done)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send(input led_cmd_t c);
      cmd_ctrl  = c.ctrl;
      cmd_time  = c.slot_time;
      cmd_valid = 1'b1;
   endtask

   task automatic drop();
      cmd_valid = 1'b0;
   endtask

   task automatic check_idle(input string tag, input logic exp_pd);
      check({tag, "_led"},  {31'd0, Led},         32'd0);
      check({tag, "_busy"}, {31'd0, busy},        32'd0);
      check({tag, "_pend"}, {31'd0, cmd_pending}, 32'd0);
`ifdef LED_SEQ_STATUS_EN
      check({tag, "_pd"},   {31'd0, period_done}, {31'd0, exp_pd});
`else
      if (exp_pd) check({tag, "_pd_unused"}, 32'd0, 32'd0);
`endif
   endtask

   // Check n running cycles; k counts cycles since the pattern started
   task automatic play(input string tag, input logic [7:0] ctrl, input int t,
                       input int k0, input int n, input logic pend, input logic pd0);
      for (int k = k0; k < k0 + n; k++) begin
         check($sformatf("%s_led@%0d", tag, k),  {31'd0, Led},         {31'd0, ctrl[(k / t) % 8]});
         check($sformatf("%s_busy@%0d", tag, k), {31'd0, busy},        32'd1);
         check($sformatf("%s_pend@%0d", tag, k), {31'd0, cmd_pending}, {31'd0, pend});
`ifdef LED_SEQ_STATUS_EN
         check($sformatf("%s_pd@%0d", tag, k),   {31'd0, period_done},
               {31'd0, ((k % (8 * t)) == 0) && (k != 0 || pd0)});
`endif
         tick();
      end
   endtask

   initial begin
      Reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_ctrl  = '0;
      cmd_time  = '0;

      // 1: reset held, then released with no command
      #2;
      check_idle("t1_rst", 1'b0);
      tick();
      tick();
      check_idle("t1_rst_held", 1'b0);
      Reset_n = 1'b1;
      tick();
      tick();
      tick();
      check_idle("t1_released", 1'b0);

      // stop command while idle is ignored
      send('{ctrl: 8'hFF, slot_time: 32'd0});
      tick();
      drop();
      check_idle("t1_idle_stop", 1'b0);
      tick();

      // 2: A5 with 3-cycle slots, two full periods
      send('{ctrl: 8'hA5, slot_time: 32'd3});
      tick();
      drop();
      play("t2", 8'hA5, 3, 0, 48, 1'b0, 1'b0);

      // 3: at slot 3 send FF/t=2; buffered until end of slot 7
      play("t3a", 8'hA5, 3, 48, 9, 1'b0, 1'b0);
      send('{ctrl: 8'hFF, slot_time: 32'd2});
      play("t3b", 8'hA5, 3, 57, 1, 1'b0, 1'b0);
      drop();
      play("t3c", 8'hA5, 3, 58, 14, 1'b1, 1'b0);
      play("t3d", 8'hFF, 2, 0, 32, 1'b0, 1'b1);

      // 4: stop mid-period; current period completes then idle
      play("t4a", 8'hFF, 2, 32, 5, 1'b0, 1'b0);
      send('{ctrl: 8'h00, slot_time: 32'd0});
      play("t4b", 8'hFF, 2, 37, 1, 1'b0, 1'b0);
      drop();
      play("t4c", 8'hFF, 2, 38, 10, 1'b1, 1'b0);
      check_idle("t4_stopped", 1'b1);
      tick();
      check_idle("t4_idle1", 1'b0);
      tick();
      check_idle("t4_idle2", 1'b0);

      // 5: two commands in one period, last write wins; then boundary bypass
      send('{ctrl: 8'h3C, slot_time: 32'd2});
      tick();
      drop();
      play("t5a", 8'h3C, 2, 0, 3, 1'b0, 1'b0);
      send('{ctrl: 8'h0F, slot_time: 32'd4});
      play("t5b", 8'h3C, 2, 3, 1, 1'b0, 1'b0);
      send('{ctrl: 8'hF0, slot_time: 32'd1});
      play("t5c", 8'h3C, 2, 4, 1, 1'b1, 1'b0);
      drop();
      play("t5d", 8'h3C, 2, 5, 11, 1'b1, 1'b0);
      play("t5e", 8'hF0, 1, 0, 7, 1'b0, 1'b1);
      send('{ctrl: 8'h81, slot_time: 32'd2});
      play("t5f", 8'hF0, 1, 7, 1, 1'b0, 1'b0);
      drop();
      play("t5g", 8'h81, 2, 0, 17, 1'b0, 1'b1);

      // 6: asynchronous reset mid-slot while Led is high
      check("t6_led_before", {31'd0, Led}, 32'd1);
      #3;
      Reset_n = 1'b0;
      #1;
      check_idle("t6_async", 1'b0);
      #2;
      Reset_n = 1'b1;
      tick();
      check_idle("t6_after1", 1'b0);
      tick();
      tick();
      check_idle("t6_after3", 1'b0);
      send('{ctrl: 8'h01, slot_time: 32'd1});
      tick();
      drop();
      play("t6_new", 8'h01, 1, 0, 9, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_led_seq_ctrl
